// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: FSM state type, frame widths and default command bytes,
// shared by spi_sram_master and spi_sram_slave.
package spi_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam int HDR_W  = 32;
    localparam int ADDR_W = 24;

    localparam logic [7:0] CMD_READ_DEF  = 8'h83;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h82;

endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: 8-bit MSB-first shift register; load has priority over sample,
// sample (shift in sin) over plain shift (shift in zero).
module spi_shift8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic       sample,
    input  logic       sin,
    input  logic [7:0] din,
    output logic [7:0] q
);

    logic [7:0] q_r;

    // Shift register state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 8'h00;
        end else if (load) begin
            q_r <= din;
        end else if (sample) begin
            q_r <= {q_r[6:0], sin};
        end else if (shift) begin
            q_r <= {q_r[6:0], 1'b0};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/spi_sram_master.sv
// spi_sram_master: SPI mode-0 master for serial SRAMs (command + 24-bit address, then data).
// Define SPI_SRAM_MASTER_BURST_EN to honour len; otherwise every transfer moves exactly one byte.
module spi_sram_master
    import spi_sram_pkg::*;
#(
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    output logic              busy,
    output logic              done,
    input  logic [7:0]        wdata,
    output logic              wdata_rd,
    output logic [7:0]        rdata,
    output logic              rdata_vld,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    state_t           state_r;
    logic             busy_r, done_r, cs_n_r, sclk_r, mosi_r;
    logic             wdata_rd_r, rdata_vld_r;
    logic [7:0]       rdata_r;
    logic             wr_r, phase_r, tail_cnt_r;
    logic [HDR_W-1:0] hdr_r;
    logic [HDR_W-1:0] hdr_init_s;
    logic [4:0]       hdr_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic             last_byte_s;
    logic             sr_load_s, sr_shift_s, sr_sample_s;
    logic [7:0]       sr_q_s;
    logic             sr_msb_unused_s;

`ifdef SPI_SRAM_MASTER_BURST_EN
    logic [7:0] len_r;
    logic [7:0] byte_cnt_r;
    assign last_byte_s = (byte_cnt_r == len_r);
`else
    logic len_unused_s;
    assign len_unused_s = ^len;
    assign last_byte_s  = 1'b1;
`endif

    assign hdr_init_s      = {(wr ? CMD_WRITE : CMD_READ), addr};
    assign sr_msb_unused_s = sr_q_s[7];

    // Data shifter controls: everything happens on the edge that ends a bit (sclk high phase)
    always_comb begin
        sr_load_s   = 1'b0;
        sr_shift_s  = 1'b0;
        sr_sample_s = 1'b0;
        if (state_r == ST_HDR && phase_r && hdr_cnt_r == 5'd31) begin
            sr_load_s = wr_r;
        end else if (state_r == ST_DATA && phase_r) begin
            sr_sample_s = !wr_r;
            if (bit_cnt_r == 3'd7) begin
                sr_load_s = wr_r && !last_byte_s;
            end else begin
                sr_shift_s = wr_r;
            end
        end else begin
            sr_load_s = 1'b0;
        end
    end

    spi_shift8 u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sr_load_s),
        .shift  (sr_shift_s),
        .sample (sr_sample_s),
        .sin    (miso),
        .din    (wdata),
        .q      (sr_q_s)
    );

    // Transaction FSM with registered SPI pins and handshake pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            sclk_r      <= 1'b0;
            mosi_r      <= 1'b0;
            wdata_rd_r  <= 1'b0;
            rdata_vld_r <= 1'b0;
            rdata_r     <= 8'h00;
            wr_r        <= 1'b0;
            phase_r     <= 1'b0;
            tail_cnt_r  <= 1'b0;
            hdr_r       <= '0;
            hdr_cnt_r   <= 5'd0;
            bit_cnt_r   <= 3'd0;
`ifdef SPI_SRAM_MASTER_BURST_EN
            len_r       <= 8'h00;
            byte_cnt_r  <= 8'h00;
`endif
        end else begin
            done_r      <= 1'b0;
            wdata_rd_r  <= 1'b0;
            rdata_vld_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= 1'b0;
                    cs_n_r <= 1'b1;
                    mosi_r <= 1'b0;
                    busy_r <= 1'b0;
                    // done_r still high here blocks acceptance, giving cs_n two idle cycles
                    if (req && !done_r) begin
                        state_r   <= ST_HDR;
                        busy_r    <= 1'b1;
                        cs_n_r    <= 1'b0;
                        wr_r      <= wr;
                        hdr_r     <= hdr_init_s;
                        mosi_r    <= hdr_init_s[HDR_W-1];
                        hdr_cnt_r <= 5'd0;
                        phase_r   <= 1'b0;
`ifdef SPI_SRAM_MASTER_BURST_EN
                        len_r      <= len;
                        byte_cnt_r <= 8'h00;
`endif
                    end
                end
                ST_HDR: begin
                    if (!phase_r) begin
                        sclk_r  <= 1'b1;
                        phase_r <= 1'b1;
                    end else begin
                        sclk_r  <= 1'b0;
                        phase_r <= 1'b0;
                        if (hdr_cnt_r == 5'd31) begin
                            state_r    <= ST_DATA;
                            bit_cnt_r  <= 3'd0;
                            mosi_r     <= wr_r ? wdata[7] : 1'b0;
                            wdata_rd_r <= wr_r;
                        end else begin
                            hdr_cnt_r <= hdr_cnt_r + 5'd1;
                            hdr_r     <= hdr_r << 1'b1;
                            mosi_r    <= hdr_r[HDR_W-2];
                        end
                    end
                end
                ST_DATA: begin
                    if (!phase_r) begin
                        sclk_r  <= 1'b1;
                        phase_r <= 1'b1;
                    end else begin
                        sclk_r  <= 1'b0;
                        phase_r <= 1'b0;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            if (!wr_r) begin
                                rdata_r     <= {sr_q_s[6:0], miso};
                                rdata_vld_r <= 1'b1;
                            end
                            if (last_byte_s) begin
                                state_r    <= ST_TAIL;
                                tail_cnt_r <= 1'b0;
                                mosi_r     <= 1'b0;
                            end else begin
`ifdef SPI_SRAM_MASTER_BURST_EN
                                byte_cnt_r <= byte_cnt_r + 8'd1;
`endif
                                mosi_r     <= wr_r ? wdata[7] : 1'b0;
                                wdata_rd_r <= wr_r;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            mosi_r    <= wr_r ? sr_q_s[6] : 1'b0;
                        end
                    end
                end
                ST_TAIL: begin
                    sclk_r <= 1'b0;
                    mosi_r <= 1'b0;
                    if (!tail_cnt_r) begin
                        tail_cnt_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cs_n_r  <= 1'b1;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign cs_n      = cs_n_r;
    assign sclk      = sclk_r;
    assign mosi      = mosi_r;
    assign wdata_rd  = wdata_rd_r;
    assign rdata     = rdata_r;
    assign rdata_vld = rdata_vld_r;

endmodule

// File: doc/spi_sram_master.md
SPI_SRAM_MASTER -- requirements
Module: spi_sram_master

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h83, read command byte.
REQ-002 SHALL have parameter CMD_WRITE, default 8'h82, write command byte.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic on posedge; rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req  in  1  start request; wr  in  1  1=write, 0=read; addr  in  24  start address; len  in  8  byte count minus 1.
REQ-005 SHALL have ports: busy  out  1  transaction in progress; done  out  1  one-cycle completion pulse.
REQ-006 SHALL have ports: wdata  in  8  write byte; wdata_rd  out  1  one-cycle pulse when wdata is consumed.
REQ-007 SHALL have ports: rdata  out  8  read byte; rdata_vld  out  1  one-cycle pulse when rdata is valid.
REQ-008 SHALL have ports: sclk  out  1  SPI clock; cs_n  out  1  chip select, active-low; mosi  out  1; miso  in  1.

Function
REQ-009 SHALL run SPI mode 0: sclk idles low, sclk = clk/2, each bit spans 2 clk cycles.
REQ-010 SHALL change mosi only while sclk is low; SHALL sample miso in the cycle sclk rises.
REQ-011 SHALL accept a request when req=1 and busy=0; SHALL latch wr, addr and len; SHALL assert busy the next cycle.
REQ-012 SHALL ignore req while busy=1.
REQ-013 SHALL implement FSM IDLE -> HDR -> DATA -> TAIL -> IDLE.
REQ-014 HDR: SHALL drive cs_n=0 and shift 32 bits MSB-first: the command byte (CMD_WRITE if wr, else CMD_READ), then addr[23:0].
REQ-015 DATA: SHALL transfer len+1 bytes MSB-first; bit counter 3 bits; byte counter 8 bits; no wrap past 255 (len=8'hFF gives 256 bytes).
REQ-016 SHALL pulse wdata_rd in the cycle wdata is loaded into the shift register: the first cycle of each write byte. The caller SHALL hold wdata valid before that cycle.
REQ-017 SHALL drive mosi=0 during read DATA bytes.
REQ-018 SHALL update rdata and pulse rdata_vld one cycle after the 8th miso sample of each read byte; SHALL NOT pulse rdata_vld on writes.
REQ-019 TAIL: SHALL hold sclk low and cs_n=0 for 1 cycle, then raise cs_n; SHALL pulse done and drop busy in that same cycle.
REQ-020 SHALL keep cs_n high for at least 2 cycles between transactions: earliest next acceptance 2 cycles after done.
REQ-021 Total busy time SHALL be 64 + 16*(len+1) + 2 cycles.
REQ-022 In IDLE SHALL drive sclk=0, cs_n=1, mosi=0.

Reset
REQ-023 rst_n=0 at a posedge SHALL force IDLE, busy=0, done=0, wdata_rd=0, rdata_vld=0, rdata=0, sclk=0, cs_n=1, mosi=0.
REQ-024 Reset mid-transaction SHALL abort it immediately (cs_n=1 next cycle) with no done pulse.

Configuration
REQ-025 With SPI_SRAM_MASTER_BURST_EN defined, len SHALL be honoured per REQ-015.
REQ-026 With SPI_SRAM_MASTER_BURST_EN undefined, len SHALL be ignored, every transaction SHALL be exactly 1 byte, and the byte counter SHALL be removed.

Structure
REQ-027 A shared package spi_sram_pkg SHALL hold the FSM state typedef, header width (32), address width (24) and default command constants, shared with spi_sram_slave.
REQ-028 One sub-module spi_shift8 (8-bit MSB-first shift register with load/shift/sample enables) SHALL be used; all else is flat.

Verification
REQ-029 Write: addr=24'h800405, len=3, wdata stream 11,22,33,44 into spi_sram_slave -> memory[405..408]=11,22,33,44; 4 wdata_rd pulses; done after 130 cycles.
REQ-030 Read back: addr=24'h800405, len=3 -> rdata_vld x4 with 11,22,33,44; mosi header bits = 83800405.
REQ-031 Single read: addr=24'h800409, preloaded 99 -> rdata=99 with one rdata_vld; cs_n low for exactly 82 cycles.
REQ-032 req held high through done -> a second transaction starts no earlier than 2 cycles after done; req while busy is ignored.
REQ-033 rst_n=0 at header bit 10 -> cs_n=1 and sclk=0 next cycle, no done; a new request afterwards completes correctly.
REQ-034 Build without SPI_SRAM_MASTER_BURST_EN, len=5 -> one byte only, busy for 82 cycles.
